// File: rtl/icmp_echo_engine_pkg.sv
// Shared constants, FSM encoding and ones'-complement helpers for the ICMP echo responder.
package icmp_echo_engine_pkg;

    localparam logic [7:0] ICMP_ECHO_REQUEST = 8'h08;
    localparam logic [7:0] ICMP_ECHO_REPLY   = 8'h00;

    // The checksum field rises by exactly the drop of the {type, code} word (RFC 1624).
    localparam logic [15:0] TYPE_DELTA = {ICMP_ECHO_REQUEST - ICMP_ECHO_REPLY, 8'h00};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_CHECK,
        ST_REQ,
        ST_WAIT,
        ST_TX,
        ST_DROP
    } state_t;

    function automatic logic [15:0] ocadd16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    function automatic logic [15:0] csum_fold(input logic [31:0] s);
        logic [31:0] f;
        f = {16'd0, s[31:16]} + {16'd0, s[15:0]};
        f = {16'd0, f[31:16]} + {16'd0, f[15:0]};
        return f[15:0];
    endfunction

endpackage

// File: rtl/icmp_echo_engine_dpram.sv
// Simple dual-port RAM with registered read; holds the echo payload between RX and TX.
module icmp_echo_engine_dpram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 11
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [DEPTH-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [DEPTH-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH];

    // NOTE: the array and its read register carry no reset so they map onto block RAM;
    // every consumer qualifies rd_data with its own reset-cleared state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/icmp_echo_engine.sv
// ICMP echo responder: verifies incoming echo requests, buffers the payload and replays it
// as an echo reply with an incrementally patched checksum.
module icmp_echo_engine #(
    parameter int PAYLOAD_AW = 11,
    parameter int TIMEOUT_W  = 16,
    parameter int STAT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icmp_rx_req,
    input  logic [15:0]       icmp_rx_len,
    input  logic              icmp_rx_valid,
    input  logic [7:0]        icmp_rx_data,
    input  logic              icmp_rev_error,
    output logic              icmp_tx_req,
    output logic              icmp_tx_ready,
    input  logic              icmp_data_req,
    output logic              icmp_tx_valid,
    output logic [7:0]        icmp_tx_data,
    output logic              icmp_tx_end,
    output logic [15:0]       icmp_tx_len,
    output logic              busy,
    output logic [STAT_W-1:0] stat_rx_ok,
    output logic [STAT_W-1:0] stat_rx_drop
);

    import icmp_echo_engine_pkg::*;

    localparam logic [31:0]          MAX_LEN  = 32'(2 ** PAYLOAD_AW) + 32'd8;
    localparam logic [STAT_W-1:0]    STAT_MAX = '1;
    localparam logic [TIMEOUT_W-1:0] TMO_MAX  = '1;

    state_t state_q, state_d;

    logic [15:0] len_q;
    logic [15:0] cnt_q;
    logic [7:0]  code_q;
    logic [15:0] rx_csum_q;
    logic [15:0] id_q;
    logic [15:0] seq_q;
    // 24 bits hold 65535 bytes of 8'hFF without overflow.
    logic [23:0] acc_even_q;
    logic [23:0] acc_odd_q;
    logic [31:0] sum_q;
    logic [15:0] fold_q;
    logic [1:0]  chk_cnt_q;

    logic [TIMEOUT_W-1:0] tmo_q;
    logic [TIMEOUT_W-1:0] tmo_next;
    logic [STAT_W-1:0]    ok_q;
    logic [STAT_W-1:0]    drop_q;

    logic        rx_byte;
    logic        rx_last;
    logic        tx_last;
    logic        len_bad;
    logic        type_bad;
    logic [15:0] reply_csum;
    logic [1:0]  drop_inc;
    logic [7:0]  tx_byte;

    logic                  ram_wr_en;
    logic [PAYLOAD_AW-1:0] ram_wr_addr;
    logic [PAYLOAD_AW-1:0] ram_rd_addr;
    logic [7:0]            ram_rd_data;

    assign rx_byte    = (state_q == ST_RX) && icmp_rx_valid;
    assign rx_last    = rx_byte && (cnt_q == len_q - 16'd1);
    assign tx_last    = (state_q == ST_TX) && (cnt_q == len_q - 16'd1);
    assign len_bad    = (len_q < 16'd8) || ({16'd0, len_q} > MAX_LEN);
    assign type_bad   = rx_byte && (cnt_q == 16'd0) && (icmp_rx_data != ICMP_ECHO_REQUEST);
    assign tmo_next   = tmo_q + TIMEOUT_W'(1);
    assign reply_csum = ocadd16(rx_csum_q, TYPE_DELTA);
    assign drop_inc   = {1'b0, state_q == ST_DROP}
                      + {1'b0, icmp_rx_req && (state_q != ST_IDLE)};

    // Payload byte k sits at message offset k+8; the read address runs one byte ahead of TX.
    assign ram_wr_en   = rx_byte && (cnt_q >= 16'd8);
    assign ram_wr_addr = cnt_q[PAYLOAD_AW-1:0] - PAYLOAD_AW'(8);
    assign ram_rd_addr = cnt_q[PAYLOAD_AW-1:0] - PAYLOAD_AW'(7);

    icmp_echo_engine_dpram #(
        .WIDTH (8),
        .DEPTH (PAYLOAD_AW)
    ) u_payload_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (icmp_rx_data),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    always_comb begin
        case (cnt_q)
            16'd0:   tx_byte = ICMP_ECHO_REPLY;
            16'd1:   tx_byte = code_q;
            16'd2:   tx_byte = reply_csum[15:8];
            16'd3:   tx_byte = reply_csum[7:0];
            16'd4:   tx_byte = id_q[15:8];
            16'd5:   tx_byte = id_q[7:0];
            16'd6:   tx_byte = seq_q[15:8];
            16'd7:   tx_byte = seq_q[7:0];
            default: tx_byte = ram_rd_data;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one
        // unassigned and infer a latch.
        state_d       = state_q;
        icmp_tx_req   = 1'b0;
        icmp_tx_ready = 1'b0;
        icmp_tx_valid = 1'b0;
        icmp_tx_end   = 1'b0;
        icmp_tx_data  = 8'h00;
        icmp_tx_len   = 16'd0;
        case (state_q)
            ST_IDLE: begin
                if (icmp_rx_req) state_d = ST_RX;
            end
            ST_RX: begin
                if (icmp_rev_error || len_bad || type_bad) state_d = ST_DROP;
                else if (rx_last)                          state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (chk_cnt_q == 2'd2) state_d = (fold_q == 16'hFFFF) ? ST_REQ : ST_DROP;
            end
            ST_REQ: begin
                icmp_tx_req = 1'b1;
                icmp_tx_len = len_q;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                icmp_tx_ready = 1'b1;
                icmp_tx_len   = len_q;
                if (icmp_data_req)          state_d = ST_TX;
                else if (tmo_next == TMO_MAX) state_d = ST_DROP;
            end
            ST_TX: begin
                icmp_tx_valid = 1'b1;
                icmp_tx_data  = tx_byte;
                icmp_tx_end   = tx_last;
                icmp_tx_len   = len_q;
                if (tx_last) state_d = ST_IDLE;
            end
            ST_DROP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= 16'd0;
            cnt_q      <= 16'd0;
            code_q     <= 8'h00;
            rx_csum_q  <= 16'd0;
            id_q       <= 16'd0;
            seq_q      <= 16'd0;
            acc_even_q <= 24'd0;
            acc_odd_q  <= 24'd0;
            sum_q      <= 32'd0;
            fold_q     <= 16'd0;
            chk_cnt_q  <= 2'd0;
            tmo_q      <= '0;
            ok_q       <= '0;
            drop_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (icmp_rx_req) begin
                        len_q      <= icmp_rx_len;
                        cnt_q      <= 16'd0;
                        acc_even_q <= 24'd0;
                        acc_odd_q  <= 24'd0;
                    end
                end
                ST_RX: begin
                    chk_cnt_q <= 2'd0;
                    if (icmp_rx_valid) begin
                        cnt_q <= cnt_q + 16'd1;
                        if (cnt_q[0]) acc_odd_q  <= acc_odd_q  + {16'd0, icmp_rx_data};
                        else          acc_even_q <= acc_even_q + {16'd0, icmp_rx_data};
                        case (cnt_q)
                            16'd1:   code_q          <= icmp_rx_data;
                            16'd2:   rx_csum_q[15:8] <= icmp_rx_data;
                            16'd3:   rx_csum_q[7:0]  <= icmp_rx_data;
                            16'd4:   id_q[15:8]      <= icmp_rx_data;
                            16'd5:   id_q[7:0]       <= icmp_rx_data;
                            16'd6:   seq_q[15:8]     <= icmp_rx_data;
                            16'd7:   seq_q[7:0]      <= icmp_rx_data;
                            default: ;
                        endcase
                    end
                end
                ST_CHECK: begin
                    // Three-stage pipeline: combine lanes, fold, then decide on fold_q.
                    chk_cnt_q <= chk_cnt_q + 2'd1;
                    sum_q     <= {acc_even_q, 8'h00} + {8'h00, acc_odd_q};
                    fold_q    <= csum_fold(sum_q);
                end
                ST_REQ: begin
                    tmo_q <= '0;
                end
                ST_WAIT: begin
                    tmo_q <= tmo_next;
                    if (icmp_data_req) cnt_q <= 16'd0;
                end
                ST_TX: begin
                    cnt_q <= cnt_q + 16'd1;
                end
                default: ;
            endcase

            if ((state_q == ST_CHECK) && (state_d == ST_REQ) && (ok_q != STAT_MAX)) begin
                ok_q <= ok_q + STAT_W'(1);
            end
            if (drop_inc != 2'd0) begin
                drop_q <= (drop_q > STAT_MAX - STAT_W'(drop_inc)) ? STAT_MAX
                                                                  : drop_q + STAT_W'(drop_inc);
            end
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign stat_rx_ok   = ok_q;
    assign stat_rx_drop = drop_q;

endmodule

// File: tb/tb_icmp_echo_engine.sv
// Directed bench for icmp_echo_engine: good/bad checksums, odd length, gaps, timeout, aborts, reset.
module tb_icmp_echo_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icmp_rx_req;
    logic [15:0] icmp_rx_len;
    logic        icmp_rx_valid;
    logic [7:0]  icmp_rx_data;
    logic        icmp_rev_error;
    logic        icmp_tx_req;
    logic        icmp_tx_ready;
    logic        icmp_data_req;
    logic        icmp_tx_valid;
    logic [7:0]  icmp_tx_data;
    logic        icmp_tx_end;
    logic [15:0] icmp_tx_len;
    logic        busy;
    logic [15:0] stat_rx_ok;
    logic [15:0] stat_rx_drop;

    int checks = 0;
    int errors = 0;
    int exp_ok = 0;
    int exp_drop = 0;

    logic [7:0] frame     [0:63];
    logic [7:0] exp_reply [0:63];

    always #5 clk = ~clk;

    icmp_echo_engine #(
        .PAYLOAD_AW (11),
        .TIMEOUT_W  (4),
        .STAT_W     (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icmp_rx_req    (icmp_rx_req),
        .icmp_rx_len    (icmp_rx_len),
        .icmp_rx_valid  (icmp_rx_valid),
        .icmp_rx_data   (icmp_rx_data),
        .icmp_rev_error (icmp_rev_error),
        .icmp_tx_req    (icmp_tx_req),
        .icmp_tx_ready  (icmp_tx_ready),
        .icmp_data_req  (icmp_data_req),
        .icmp_tx_valid  (icmp_tx_valid),
        .icmp_tx_data   (icmp_tx_data),
        .icmp_tx_end    (icmp_tx_end),
        .icmp_tx_len    (icmp_tx_len),
        .busy           (busy),
        .stat_rx_ok     (stat_rx_ok),
        .stat_rx_drop   (stat_rx_drop)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Echo request with the given header; payload bytes 8..9 are chosen so the message sums to FFFF.
    task automatic build_frame(input int len, input logic [15:0] id, input logic [15:0] seq,
                               input logic [15:0] csum);
        logic [31:0] s;
        logic [7:0]  lo;
        logic [15:0] fix;
        frame[0] = 8'h08;
        frame[1] = 8'h00;
        frame[2] = csum[15:8];
        frame[3] = csum[7:0];
        frame[4] = id[15:8];
        frame[5] = id[7:0];
        frame[6] = seq[15:8];
        frame[7] = seq[7:0];
        for (int i = 8; i < 64; i++) frame[i] = 8'((i * 7 + 3) & 255);
        frame[8] = 8'h00;
        frame[9] = 8'h00;
        if (len % 2 == 1) frame[len-1] = 8'hAB;
        s = 32'd0;
        for (int i = 0; i < len; i += 2) begin
            lo = (i + 1 < len) ? frame[i+1] : 8'h00;
            s  = s + {16'd0, frame[i], lo};
        end
        s   = {16'd0, s[31:16]} + {16'd0, s[15:0]};
        s   = {16'd0, s[31:16]} + {16'd0, s[15:0]};
        fix = ~s[15:0];
        frame[8] = fix[15:8];
        frame[9] = fix[7:0];
    endtask

    task automatic set_expect(input int len, input logic [7:0] csum_hi, input logic [7:0] csum_lo);
        for (int i = 0; i < len; i++) exp_reply[i] = frame[i];
        exp_reply[0] = 8'h00;
        exp_reply[2] = csum_hi;
        exp_reply[3] = csum_lo;
    endtask

    // Returns on the falling edge after the last byte (or the aborted byte) was sampled.
    task automatic send_frame(input int len, input int gap_at, input int gap_n, input int err_at);
        @(negedge clk);
        icmp_rx_req = 1'b1;
        icmp_rx_len = 16'(len);
        @(negedge clk);
        icmp_rx_req = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (i == gap_at) begin
                icmp_rx_valid = 1'b0;
                repeat (gap_n) @(negedge clk);
            end
            icmp_rx_valid  = 1'b1;
            icmp_rx_data   = frame[i];
            icmp_rev_error = (i == err_at);
            @(negedge clk);
            if (i == err_at) break;
        end
        icmp_rx_valid  = 1'b0;
        icmp_rev_error = 1'b0;
    endtask

    task automatic expect_accept(input string name, input int len, input bit intrude);
        exp_ok++;
        repeat (3) @(negedge clk);
        check({name, "_tx_req"}, icmp_tx_req, 1);
        check({name, "_tx_len"}, icmp_tx_len, 32'(len));
        @(negedge clk);
        check({name, "_tx_req_pulse"}, icmp_tx_req, 0);
        check({name, "_tx_ready"}, icmp_tx_ready, 1);
        if (intrude) begin
            icmp_rx_req = 1'b1;
            icmp_rx_len = 16'd40;
            exp_drop++;
            @(negedge clk);
            icmp_rx_req = 1'b0;
            check({name, "_ready_after_intrude"}, icmp_tx_ready, 1);
        end
        icmp_data_req = 1'b1;
        @(negedge clk);
        icmp_data_req = 1'b0;
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s_tx_valid%0d", name, i), icmp_tx_valid, 1);
            check($sformatf("%s_tx_byte%0d", name, i), icmp_tx_data, exp_reply[i]);
            check($sformatf("%s_tx_end%0d", name, i), icmp_tx_end, (i == len - 1) ? 1 : 0);
            @(negedge clk);
        end
        check({name, "_tx_valid_after"}, icmp_tx_valid, 0);
        check({name, "_busy_after"}, busy, 0);
        check({name, "_stat_ok"}, stat_rx_ok, 32'(exp_ok));
        check({name, "_stat_drop"}, stat_rx_drop, 32'(exp_drop));
    endtask

    // Call on the falling edge where the FSM is expected to sit in DROP.
    task automatic expect_drop_now(input string name);
        exp_drop++;
        check({name, "_tx_req"}, icmp_tx_req, 0);
        check({name, "_busy_drop"}, busy, 1);
        @(negedge clk);
        check({name, "_busy_idle"}, busy, 0);
        check({name, "_stat_drop"}, stat_rx_drop, 32'(exp_drop));
        check({name, "_stat_ok"}, stat_rx_ok, 32'(exp_ok));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n          = 1'b1;
        icmp_rx_req    = 1'b0;
        icmp_rx_len    = 16'd0;
        icmp_rx_valid  = 1'b0;
        icmp_rx_data   = 8'h00;
        icmp_rev_error = 1'b0;
        icmp_data_req  = 1'b0;
        #3 rst_n = 1'b0;
        #10;
        check("rst_busy", busy, 0);
        check("rst_tx_req", icmp_tx_req, 0);
        check("rst_tx_ready", icmp_tx_ready, 0);
        check("rst_tx_valid", icmp_tx_valid, 0);
        check("rst_tx_end", icmp_tx_end, 0);
        check("rst_tx_data", icmp_tx_data, 0);
        check("rst_tx_len", icmp_tx_len, 0);
        check("rst_stat_ok", stat_rx_ok, 0);
        check("rst_stat_drop", stat_rx_drop, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Valid echo request, checksum F7FF -> reply checksum FFFF.
        build_frame(40, 16'h1234, 16'h0001, 16'hF7FF);
        set_expect(40, 8'hFF, 8'hFF);
        send_frame(40, -1, 0, -1);
        expect_accept("t1", 40, 1'b0);

        // One payload bit flipped -> checksum failure.
        frame[20] = frame[20] ^ 8'h01;
        send_frame(40, -1, 0, -1);
        repeat (3) @(negedge clk);
        expect_drop_now("t2");

        // Odd length with checksum F800 -> reply checksum wraps to 0001.
        build_frame(41, 16'hABCD, 16'h0102, 16'hF800);
        set_expect(41, 8'h00, 8'h01);
        send_frame(41, -1, 0, -1);
        expect_accept("t3", 41, 1'b0);
        check("t3_last_byte_model", exp_reply[40], 8'hAB);

        // Three-cycle valid gap mid-payload -> identical reply.
        build_frame(40, 16'h1234, 16'h0001, 16'hF7FF);
        set_expect(40, 8'hFF, 8'hFF);
        send_frame(40, 20, 3, -1);
        expect_accept("t4", 40, 1'b0);

        // Grant never given -> 15 cycles of tx_ready, then drop.
        send_frame(40, -1, 0, -1);
        exp_ok++;
        repeat (3) @(negedge clk);
        check("t5_tx_req", icmp_tx_req, 1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!icmp_tx_ready) break;
            n++;
        end
        check("t5_ready_cycles", n, 15);
        expect_drop_now("t5");

        // Abort from MAC at byte 20.
        send_frame(40, -1, 0, 20);
        expect_drop_now("t6_abort");

        // Length below header size and one byte beyond the payload limit.
        @(negedge clk); icmp_rx_req = 1'b1; icmp_rx_len = 16'd5;
        @(negedge clk); icmp_rx_req = 1'b0;
        @(negedge clk);
        expect_drop_now("t6_short");
        @(negedge clk); icmp_rx_req = 1'b1; icmp_rx_len = 16'd2057;
        @(negedge clk); icmp_rx_req = 1'b0;
        @(negedge clk);
        expect_drop_now("t6_oversize");

        // Wrong type byte.
        @(negedge clk); icmp_rx_req = 1'b1; icmp_rx_len = 16'd40;
        @(negedge clk); icmp_rx_req = 1'b0; icmp_rx_valid = 1'b1; icmp_rx_data = 8'h00;
        @(negedge clk); icmp_rx_valid = 1'b0;
        expect_drop_now("t6_type");

        // New request while waiting for grant: counted as drop, reply unaffected.
        send_frame(40, -1, 0, -1);
        expect_accept("t6_busy", 40, 1'b1);

        // Asynchronous reset mid-TX.
        send_frame(40, -1, 0, -1);
        repeat (4) @(negedge clk);
        icmp_data_req = 1'b1;
        @(negedge clk);
        icmp_data_req = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_pre_rst_valid", icmp_tx_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_tx_valid", icmp_tx_valid, 0);
        check("t6_rst_tx_end", icmp_tx_end, 0);
        check("t6_rst_tx_data", icmp_tx_data, 0);
        check("t6_rst_tx_len", icmp_tx_len, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_stat_ok", stat_rx_ok, 0);
        check("t6_rst_stat_drop", stat_rx_drop, 0);
        exp_ok   = 0;
        exp_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;

        send_frame(40, -1, 0, -1);
        expect_accept("post_rst", 40, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
